// File: rtl/fifo_dp_ram.sv
// fifo_dp_ram: simple dual-port RAM, synchronous write port, asynchronous read port
module fifo_dp_ram #(
   parameter int A_WIDTH = 4,
   parameter int D_WIDTH = 16
) (
   input  logic               clk,
   input  logic               we,
   input  logic [A_WIDTH-1:0] wa,
   input  logic [D_WIDTH-1:0] wd,
   input  logic [A_WIDTH-1:0] ra,
   output logic [D_WIDTH-1:0] rd
);
   logic [D_WIDTH-1:0] mem [0:(2**A_WIDTH)-1];
   // store the incoming word; contents are deliberately never reset
   always_ff @(posedge clk)
      if (we) mem[wa] <= wd;
   assign rd = mem[ra];
endmodule

// File: rtl/small_sync_fifo.sv
// small_sync_fifo: single-clock first-word-fall-through FIFO with wrap-bit pointers
module small_sync_fifo #(
   parameter int A_WIDTH = 4,
   parameter int D_WIDTH = 16
) (
   input  logic               CLK,
   input  logic               rst_n,
   input  logic [D_WIDTH-1:0] din,
   input  logic               wr_en,
   output logic               full,
   output logic [D_WIDTH-1:0] dout,
   input  logic               rd_en,
   output logic               empty
);
   logic [A_WIDTH:0]   wr_ptr, rd_ptr;
   logic [D_WIDTH-1:0] ram_rd;
   logic               wr_ok, rd_ok;
   assign empty = wr_ptr == rd_ptr;
   assign full  = (wr_ptr[A_WIDTH-1:0] == rd_ptr[A_WIDTH-1:0]) && (wr_ptr[A_WIDTH] != rd_ptr[A_WIDTH]);
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;
   assign dout  = empty ? '0 : ram_rd;
   fifo_dp_ram #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) u_ram (
      .clk(CLK),
      .we (wr_ok),
      .wa (wr_ptr[A_WIDTH-1:0]),
      .wd (din),
      .ra (rd_ptr[A_WIDTH-1:0]),
      .rd (ram_rd)
   );
   // advance each pointer only on an accepted transfer; reset empties immediately
   always_ff @(posedge CLK or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + (A_WIDTH+1)'(1);
         if (rd_ok) rd_ptr <= rd_ptr + (A_WIDTH+1)'(1);
      end
endmodule

// File: tb/tb_small_sync_fifo.sv
// tb_small_sync_fifo: directed checks of a 4-deep and a 64K-deep byte FIFO
module tb_small_sync_fifo;
   logic       clk = 0;
   logic       rst_n = 0;
   logic [7:0] din_a = 0, dout_a, din_b = 0, dout_b;
   logic       wr_a = 0, rd_a = 0, full_a, empty_a;
   logic       wr_b = 0, rd_b = 0, full_b, empty_b;
   int         checks = 0, errors = 0;
   logic [63:0] str = "mypwd123";
   logic [7:0]  exp_rd, nxt;

   small_sync_fifo #(.A_WIDTH(2), .D_WIDTH(8)) dut_a (
      .CLK(clk), .rst_n(rst_n), .din(din_a), .wr_en(wr_a),
      .full(full_a), .dout(dout_a), .rd_en(rd_a), .empty(empty_a)
   );
   small_sync_fifo #(.A_WIDTH(16), .D_WIDTH(8)) dut_b (
      .CLK(clk), .rst_n(rst_n), .din(din_b), .wr_en(wr_b),
      .full(full_b), .dout(dout_b), .rd_en(rd_b), .empty(empty_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      chk("rst_empty", 16'(empty_a), 16'd1);
      chk("rst_full", 16'(full_a), 16'd0);
      chk("rst_dout", 16'(dout_a), 16'h00);
      @(negedge clk);
      rst_n = 1;
      step;
      // single write, held until popped
      din_a = 8'hA5; wr_a = 1;
      step;
      wr_a = 0;
      chk("one_empty", 16'(empty_a), 16'd0);
      chk("one_dout", 16'(dout_a), 16'hA5);
      step;
      chk("one_hold", 16'(dout_a), 16'hA5);
      rd_a = 1;
      step;
      rd_a = 0;
      chk("one_pop_empty", 16'(empty_a), 16'd1);
      chk("one_pop_dout", 16'(dout_a), 16'h00);
      // fill, overflow attempt, drain
      for (int i = 1; i <= 4; i++) begin
         chk("fill_notfull", 16'(full_a), 16'd0);
         din_a = 8'(i); wr_a = 1;
         step;
      end
      chk("fill_full", 16'(full_a), 16'd1);
      din_a = 8'hFF;
      step;
      wr_a = 0;
      chk("ovf_full", 16'(full_a), 16'd1);
      for (int i = 1; i <= 4; i++) begin
         chk("drain_dout", 16'(dout_a), 16'(i));
         rd_a = 1;
         step;
         rd_a = 0;
      end
      chk("drain_empty", 16'(empty_a), 16'd1);
      chk("drain_dout0", 16'(dout_a), 16'h00);
      // streaming with occupancy 2 across wraps
      for (int i = 0; i < 2; i++) begin
         din_a = 8'h10 + 8'(i); wr_a = 1;
         step;
      end
      exp_rd = 8'h10; nxt = 8'h12;
      for (int i = 0; i < 20; i++) begin
         chk("stream_dout", 16'(dout_a), 16'(exp_rd));
         chk("stream_flags", {14'd0, empty_a, full_a}, 16'd0);
         din_a = nxt; wr_a = 1; rd_a = 1;
         step;
         exp_rd++; nxt++;
      end
      wr_a = 0;
      for (int i = 0; i < 2; i++) begin
         chk("stream_tail", 16'(dout_a), 16'(exp_rd));
         step;
         exp_rd++;
      end
      rd_a = 0;
      chk("stream_empty", 16'(empty_a), 16'd1);
      // read on empty is ignored
      rd_a = 1;
      for (int i = 0; i < 3; i++) begin
         step;
         chk("rde_empty", 16'(empty_a), 16'd1);
         chk("rde_dout", 16'(dout_a), 16'h00);
      end
      rd_a = 0;
      for (int i = 0; i < 4; i++) begin
         din_a = 8'h31 + 8'(i); wr_a = 1;
         step;
      end
      // write on full is dropped
      din_a = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         step;
         chk("wrf_full", 16'(full_a), 16'd1);
         chk("wrf_dout", 16'(dout_a), 16'h31);
      end
      // read+write while full: only the read is taken
      din_a = 8'h77; rd_a = 1;
      step;
      wr_a = 0; rd_a = 0;
      chk("rwf_full", 16'(full_a), 16'd0);
      for (int i = 0; i < 3; i++) begin
         chk("rwf_dout", 16'(dout_a), 16'h32 + 16'(i));
         rd_a = 1;
         step;
         rd_a = 0;
      end
      chk("rwf_empty", 16'(empty_a), 16'd1);
      // byte stream through the deep instance, consumer always ready
      rd_b = 1;
      for (int i = 0; i < 8; i++) begin
         din_b = str[63-8*i -: 8]; wr_b = 1;
         step;
         chk("str_empty", 16'(empty_b), 16'd0);
         chk("str_dout", 16'(dout_b), 16'(str[63-8*i -: 8]));
      end
      wr_b = 0;
      step;
      rd_b = 0;
      chk("str_end_empty", 16'(empty_b), 16'd1);
      // reset mid-operation with requests asserted
      for (int i = 0; i < 2; i++) begin
         din_a = 8'h55 + 8'(i); wr_a = 1;
         step;
      end
      din_a = 8'h99; rd_a = 1;
      #2 rst_n = 0;
      #1;
      chk("mrst_empty", 16'(empty_a), 16'd1);
      chk("mrst_full", 16'(full_a), 16'd0);
      chk("mrst_dout", 16'(dout_a), 16'h00);
      step;
      chk("mrst_hold", 16'(empty_a), 16'd1);
      rst_n = 1; wr_a = 0; rd_a = 0;
      din_a = 8'hC3; wr_a = 1;
      step;
      wr_a = 0;
      chk("post_rst_dout", 16'(dout_a), 16'hC3);
      rd_a = 1;
      step;
      rd_a = 0;
      chk("post_rst_empty", 16'(empty_a), 16'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
